// File: rtl/uart_baud_gen_pkg.sv
// Shared UART timing constants and the reset-divisor calculation.
// Imported by uart_baud_gen and the uart_rx/uart_tx blocks.
package uart_baud_gen_pkg;

    localparam int UART_CLK_FREQ     = 50_000_000;
    localparam int UART_BAUD_RATE    = 19200;
    localparam int UART_OVERSAMPLING = 16;
    localparam int UART_NB_DIV       = 16;
    localparam int UART_NB_FRAC      = 4;

    // Clock cycles per oversampling tick, truncated toward zero.
    function automatic int calc_default_div(input int clk_freq, input int baud, input int os);
        return clk_freq / (baud * os);
    endfunction

    localparam int UART_DEFAULT_DIV =
        calc_default_div(UART_CLK_FREQ, UART_BAUD_RATE, UART_OVERSAMPLING);

endpackage

// File: rtl/uart_baud_gen_if.sv
// Configuration and tick bundle between the UART register block and the baud generator.
// master = config side (drives divisor/enable), slave = generator (drives ticks).
interface uart_baud_gen_if #(
    parameter int NB_DIV  = 16,
    parameter int NB_FRAC = 4
) ();

    logic               i_en;
    logic [NB_DIV-1:0]  i_div;
    logic               i_div_wr;
    logic [NB_FRAC-1:0] i_frac;
    logic               o_tick;
    logic               o_bit_tick;
    logic               o_mid_tick;
    logic [NB_DIV-1:0]  o_div;

    modport master (
        output i_en, i_div, i_div_wr, i_frac,
        input  o_tick, o_bit_tick, o_mid_tick, o_div
    );

    modport slave (
        input  i_en, i_div, i_div_wr, i_frac,
        output o_tick, o_bit_tick, o_mid_tick, o_div
    );

endinterface

// File: rtl/uart_baud_gen_frac_acc.sv
// Fractional-divisor accumulator: adds the fraction at every period end and flags
// (registered) that the following period must be stretched by one clock.
module uart_baud_gen_frac_acc #(
    parameter int NB_FRAC = 4
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_clr,
    input  logic               i_adv,
    input  logic [NB_FRAC-1:0] i_frac,
    output logic               o_extra
);

    logic [NB_FRAC-1:0] acc_r;
    logic               extra_r;

    // Accumulator and carry register; a carry stretches exactly the next period.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_r   <= {NB_FRAC{1'b0}};
            extra_r <= 1'b0;
        end else if (i_clr) begin
            acc_r   <= {NB_FRAC{1'b0}};
            extra_r <= 1'b0;
        end else if (i_adv) begin
            {extra_r, acc_r} <= {1'b0, acc_r} + {1'b0, i_frac};
        end else begin
            acc_r   <= acc_r;
            extra_r <= extra_r;
        end
    end

    assign o_extra = extra_r;

endmodule

// File: rtl/uart_baud_gen.sv
// Programmable baud tick generator: clk / divisor -> os tick, / OVERSAMPLING -> bit/mid ticks.
// Optional fractional divisor enabled by defining UART_BAUD_FRAC_EN.
module uart_baud_gen
    import uart_baud_gen_pkg::*;
#(
    parameter int CLK_FREQ     = UART_CLK_FREQ,
    parameter int BAUD_RATE    = UART_BAUD_RATE,
    parameter int OVERSAMPLING = UART_OVERSAMPLING,
    parameter int NB_DIV       = UART_NB_DIV,
    parameter int NB_FRAC      = UART_NB_FRAC,
    parameter int DEFAULT_DIV  = calc_default_div(CLK_FREQ, BAUD_RATE, OVERSAMPLING)
) (
    input  logic           clk,
    input  logic           i_rst_n,
    uart_baud_gen_if.slave bus
);

    localparam int                NB_OS     = $clog2(OVERSAMPLING);
    localparam logic [NB_DIV-1:0] DEF_DIV_C = NB_DIV'(DEFAULT_DIV);
    localparam logic [NB_DIV-1:0] ONE_C     = NB_DIV'(1);
    localparam logic [NB_OS-1:0]  OS_LAST_C = NB_OS'(OVERSAMPLING - 1);
    localparam logic [NB_OS-1:0]  OS_MID_C  = NB_OS'(OVERSAMPLING / 2 - 1);

    logic [NB_DIV-1:0] cnt_r,         cnt_s;
    logic [NB_DIV-1:0] active_div_r,  active_div_s;
    logic [NB_DIV-1:0] pending_div_r, pending_div_s;
    logic [NB_DIV-1:0] eff_div_s,     term_s;
    logic [NB_OS-1:0]  os_cnt_r,      os_cnt_s;
    logic              tick_r,        tick_s;
    logic              bit_tick_r,    bit_tick_s;
    logic              mid_tick_r,    mid_tick_s;
    logic              period_end_s;
    logic              extra_s;

    // Counter, os counter, tick and divisor-shadow next-state logic.
    always_comb begin
        cnt_s         = cnt_r;
        os_cnt_s      = os_cnt_r;
        tick_s        = 1'b0;
        bit_tick_s    = 1'b0;
        mid_tick_s    = 1'b0;
        period_end_s  = 1'b0;
        active_div_s  = active_div_r;
        // A write on a boundary cycle bypasses pending so it governs the very next period.
        pending_div_s = bus.i_div_wr ? bus.i_div : pending_div_r;
        eff_div_s     = (active_div_r == {NB_DIV{1'b0}}) ? ONE_C : active_div_r;
        term_s        = extra_s ? eff_div_s : (eff_div_s - ONE_C);

        if (!bus.i_en) begin
            cnt_s        = {NB_DIV{1'b0}};
            os_cnt_s     = {NB_OS{1'b0}};
            active_div_s = pending_div_s;
        end else if (cnt_r == term_s) begin
            cnt_s        = {NB_DIV{1'b0}};
            tick_s       = 1'b1;
            bit_tick_s   = (os_cnt_r == OS_LAST_C);
            mid_tick_s   = (os_cnt_r == OS_MID_C);
            os_cnt_s     = os_cnt_r + NB_OS'(1);
            active_div_s = pending_div_s;
            period_end_s = 1'b1;
        end else begin
            cnt_s        = cnt_r + ONE_C;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_r         <= {NB_DIV{1'b0}};
            os_cnt_r      <= {NB_OS{1'b0}};
            tick_r        <= 1'b0;
            bit_tick_r    <= 1'b0;
            mid_tick_r    <= 1'b0;
            active_div_r  <= DEF_DIV_C;
            pending_div_r <= DEF_DIV_C;
        end else begin
            cnt_r         <= cnt_s;
            os_cnt_r      <= os_cnt_s;
            tick_r        <= tick_s;
            bit_tick_r    <= bit_tick_s;
            mid_tick_r    <= mid_tick_s;
            active_div_r  <= active_div_s;
            pending_div_r <= pending_div_s;
        end
    end

`ifdef UART_BAUD_FRAC_EN
    logic [NB_FRAC-1:0] active_frac_r,  active_frac_s;
    logic [NB_FRAC-1:0] pending_frac_r, pending_frac_s;

    // Fraction shadows follow the same pending/active rules as the integer divisor.
    always_comb begin
        pending_frac_s = bus.i_div_wr ? bus.i_frac : pending_frac_r;
        if (!bus.i_en || period_end_s) begin
            active_frac_s = pending_frac_s;
        end else begin
            active_frac_s = active_frac_r;
        end
    end

    // Fraction shadow registers.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            active_frac_r  <= {NB_FRAC{1'b0}};
            pending_frac_r <= {NB_FRAC{1'b0}};
        end else begin
            active_frac_r  <= active_frac_s;
            pending_frac_r <= pending_frac_s;
        end
    end

    uart_baud_gen_frac_acc #(
        .NB_FRAC (NB_FRAC)
    ) u_frac_acc (
        .clk     (clk),
        .i_rst_n (i_rst_n),
        .i_clr   (!bus.i_en),
        .i_adv   (period_end_s),
        .i_frac  (active_frac_r),
        .o_extra (extra_s)
    );
`else
    logic unused_frac_s;
    assign unused_frac_s = ^bus.i_frac;
    assign extra_s       = 1'b0;
`endif

    assign bus.o_tick     = tick_r;
    assign bus.o_bit_tick = bit_tick_r;
    assign bus.o_mid_tick = mid_tick_r;
    assign bus.o_div      = active_div_r;

endmodule
